// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive FIFO that sits behind the UART receiver. It presents buffered bytes to the
// 65C02 bus through a two-register read port: DATA at addr=0 and STATUS at addr=1.
// It also keeps sticky overrun and break flags and drives a registered level interrupt.
//
// Ports
//   clk       system clock
//   resetn    synchronous, active-low reset
//   rx_valid  one-cycle pulse from the receiver when a frame completes
//   rx_data   received payload, qualified by rx_valid
//   rx_break  the completed frame was a BREAK; the payload is not stored
//   cs, rd    chip select and read strobe; a read happens when both are high
//   addr      register select: 0 = DATA (pop), 1 = STATUS
//   irq_en    interrupt enable
//   rd_data   registered read data, held between reads
//   irq       level interrupt: irq_en & (not_empty | ovr | brk), one cycle late
//   rx_count  FIFO occupancy, 0..DEPTH
module uart_rx_fifo #(
    parameter int DEPTH        = 16,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      rx_valid,
    input  logic [PAYLOAD_BITS-1:0]   rx_data,
    input  logic                      rx_break,
    input  logic                      cs,
    input  logic                      rd,
    input  logic                      addr,
    input  logic                      irq_en,
    output logic [PAYLOAD_BITS-1:0]   rd_data,
    output logic                      irq,
    output logic [$clog2(DEPTH):0]    rx_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PAYLOAD_BITS-1:0] mem [DEPTH];

    logic [AW-1:0]           wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]           rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]           count_reg,  count_next;
    logic                    ovr_reg,    ovr_next;
    logic                    brk_reg,    brk_next;
    logic                    irq_reg,    irq_next;
    logic [PAYLOAD_BITS-1:0] rd_data_reg;

    logic pop_req, stat_req;
    logic empty, full, half;
    logic pop_taken, push_req, push_accepted;
    logic overrun_event, break_event;
    logic [PAYLOAD_BITS-1:0] status_word;

    assign pop_req  = cs & rd & ~addr;
    assign stat_req = cs & rd &  addr;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));
    assign half  = (count_reg >= CW'(DEPTH / 2));

    // A pop in the same cycle frees a slot, so a push into a full FIFO
    // is accepted whenever a real (non-empty) pop happens alongside it.
    assign pop_taken     = pop_req & ~empty;
    assign push_req      = rx_valid & ~rx_break;
    assign push_accepted = push_req & (~full | pop_taken);
    assign overrun_event = push_req & full & ~pop_taken;
    assign break_event   = rx_valid & rx_break;

    // The status bits use the state from before the edge. Bits above bit 4 read as zero.
    assign status_word[4:0] = {full, half, brk_reg, ovr_reg, ~empty};
    generate
        for (genvar gi = 5; gi < PAYLOAD_BITS; gi++) begin : g_status_pad
            assign status_word[gi] = 1'b0;
        end
    endgenerate

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (push_accepted) wr_ptr_next = wr_ptr_reg + AW'(1);
        if (pop_taken)     rd_ptr_next = rd_ptr_reg + AW'(1);
        count_next = count_reg + CW'(push_accepted) - CW'(pop_taken);
        // If an event sets a flag in the same cycle that a status read clears it, the flag stays set.
        ovr_next = overrun_event | (ovr_reg & ~stat_req);
        brk_next = break_event   | (brk_reg & ~stat_req);
        irq_next = irq_en & (~empty | ovr_reg | brk_reg);
    end

    // Storage has no reset. It is written only while out of reset, so a frame
    // that arrives in the reset cycle is discarded.
    always_ff @(posedge clk) begin
        if (resetn && push_accepted)
            mem[wr_ptr_reg] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            ovr_reg     <= 1'b0;
            brk_reg     <= 1'b0;
            irq_reg     <= 1'b0;
            rd_data_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            ovr_reg    <= ovr_next;
            brk_reg    <= brk_next;
            irq_reg    <= irq_next;
            if (pop_req)
                rd_data_reg <= pop_taken ? mem[rd_ptr_reg] : '0;
            else if (stat_req)
                rd_data_reg <= status_word;
        end
    end

    assign rd_data  = rd_data_reg;
    assign irq      = irq_reg;
    assign rx_count = count_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo. Each read pushes its expected value onto
// exp_q when it is issued. A separate monitor detects each read strobe at the
// clock edge, samples rd_data 1 ns later, and compares it with the head of the queue.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int PB    = 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic          rx_valid;
    logic [PB-1:0] rx_data;
    logic          rx_break;
    logic          cs, rd, addr;
    logic          irq_en;
    logic [PB-1:0] rd_data;
    logic          irq;
    logic [4:0]    rx_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [PB-1:0] exp_q [$];

    uart_rx_fifo #(.DEPTH(DEPTH), .PAYLOAD_BITS(PB)) dut (
        .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_break(rx_break), .cs(cs), .rd(rd), .addr(addr), .irq_en(irq_en),
        .rd_data(rd_data), .irq(irq), .rx_count(rx_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: on every edge that carries a read strobe, sample the result 1 ns later.
    always @(posedge clk) begin
        if (resetn && cs && rd) begin
            #1;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL read: got 0x%0h with no expected value queued", rd_data);
            end else begin
                check(addr ? "status read" : "data read", int'(rd_data), int'(exp_q.pop_front()));
            end
        end
    end

    // All drive tasks start and end on a falling edge.
    task automatic push(input logic [PB-1:0] b, input logic brk);
        rx_valid = 1'b1; rx_data = b; rx_break = brk;
        @(negedge clk);
        rx_valid = 1'b0; rx_break = 1'b0;
    endtask

    task automatic rd_reg(input logic a, input logic [PB-1:0] exp);
        cs = 1'b1; rd = 1'b1; addr = a;
        exp_q.push_back(exp);
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
    endtask

    // Issue a read and a receiver frame in the same cycle.
    task automatic rd_and_push(input logic a, input logic [PB-1:0] exp,
                               input logic [PB-1:0] b, input logic brk);
        rx_valid = 1'b1; rx_data = b; rx_break = brk;
        cs = 1'b1; rd = 1'b1; addr = a;
        exp_q.push_back(exp);
        @(negedge clk);
        rx_valid = 1'b0; rx_break = 1'b0; cs = 1'b0; rd = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; rx_valid = 1'b0; rx_data = '0; rx_break = 1'b0;
        cs = 1'b0; rd = 1'b0; addr = 1'b0; irq_en = 1'b1;
        @(negedge clk); @(negedge clk);
        resetn = 1'b1;
        check("reset rx_count", int'(rx_count), 0);
        check("reset rd_data", int'(rd_data), 0);
        check("reset irq", int'(irq), 0);

        // Basic ordering.
        push(8'h41, 1'b0); push(8'h42, 1'b0); push(8'h43, 1'b0);
        check("count after 3 pushes", int'(rx_count), 3);
        check("irq with data", int'(irq), 1);
        rd_reg(1'b1, 8'h01);
        rd_reg(1'b0, 8'h41); rd_reg(1'b0, 8'h42); rd_reg(1'b0, 8'h43);
        rd_reg(1'b1, 8'h00);
        check("count after drain", int'(rx_count), 0);
        @(negedge clk);
        check("irq after drain", int'(irq), 0);

        // Overfill: the 17th byte is dropped and sets ovr.
        for (int i = 0; i < 17; i++) push(8'(i), 1'b0);
        check("count full", int'(rx_count), 16);
        rd_reg(1'b1, 8'h1B);
        // A simultaneous pop and push on a full FIFO: the push is accepted and ovr stays 0.
        rd_and_push(1'b0, 8'h00, 8'h55, 1'b0);
        check("count full after push+pop", int'(rx_count), 16);
        rd_reg(1'b1, 8'h19);
        for (int i = 1; i < 16; i++) rd_reg(1'b0, 8'(i));
        rd_reg(1'b0, 8'h55);
        rd_reg(1'b1, 8'h00);

        // A break sets brk and does not store the byte.
        push(8'h00, 1'b1);
        check("count after break", int'(rx_count), 0);
        check("irq not yet after break", int'(irq), 0);
        @(negedge clk);
        check("irq after break", int'(irq), 1);
        rd_reg(1'b1, 8'h04);
        check("irq still set after first status", int'(irq), 1);
        rd_reg(1'b1, 8'h00);
        check("irq dropped", int'(irq), 0);

        // Read from an empty FIFO. Then a break arrives during a status read.
        rd_reg(1'b0, 8'h00);
        check("count empty read", int'(rx_count), 0);
        rd_and_push(1'b1, 8'h00, 8'h00, 1'b1);
        rd_reg(1'b1, 8'h04);
        rd_reg(1'b1, 8'h00);

        // Reset with buffered data and a frame in the same cycle.
        for (int i = 0; i < 5; i++) push(8'(8'h60 + i), 1'b0);
        rd_reg(1'b0, 8'h60);
        @(negedge clk);
        check("irq before reset", int'(irq), 1);
        resetn = 1'b0; rx_valid = 1'b1; rx_data = 8'h77; rx_break = 1'b1;
        @(negedge clk);
        resetn = 1'b1; rx_valid = 1'b0; rx_break = 1'b0;
        check("mid reset rx_count", int'(rx_count), 0);
        check("mid reset rd_data", int'(rd_data), 0);
        check("mid reset irq", int'(irq), 0);
        rd_reg(1'b1, 8'h00);
        push(8'h99, 1'b0);
        check("count after reset push", int'(rx_count), 1);
        rd_reg(1'b0, 8'h99);
        rd_reg(1'b1, 8'h00);

        @(negedge clk); @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
